// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-to-ALU framer: state encoding and parameter defaults.
package uart_alu_pkg;

   localparam int unsigned DBIT_DEF    = 8;
   localparam int unsigned NBITS_DEF   = 16;
   localparam int unsigned COD_OP_DEF  = 6;
   localparam int unsigned TIMEOUT_DEF = 50000;

   typedef enum logic [2:0] {
      ST_RX_A    = 3'd0,
      ST_RX_B    = 3'd1,
      ST_RX_OP   = 3'd2,
      ST_EXEC    = 3'd3,
      ST_TX_SEND = 3'd4,
      ST_TX_WAIT = 3'd5
   } state_e;

endpackage

// File: rtl/rx_idle_timer.sv
// Inter-byte idle counter; expired flags the cycle whose edge would bring the count to TIMEOUT.
module rx_idle_timer #(
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   generate
      if (TIMEOUT == 0) begin : g_off
         logic unused_c;
         assign unused_c = ^{clk, reset, clear, enable};
         assign expired  = 1'b0;
      end else begin : g_on
         localparam int unsigned TW = $clog2(TIMEOUT + 1);
         logic [TW-1:0] count_q;
         logic [TW-1:0] count_d;

         // A clear in the same cycle always beats expiry.
         assign expired = enable && !clear && (count_q == TW'(TIMEOUT - 1));

         always_comb begin
            count_d = count_q;
            if (clear || expired) begin
               count_d = '0;
            end else if (enable) begin
               count_d = count_q + TW'(1);
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               count_q <= '0;
            end else begin
               count_q <= count_d;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/uart_alu_framer.sv
// Assembles multi-byte A/B operands and an opcode from the UART RX stream and
// returns the ALU result byte-by-byte over the TX handshake.
module uart_alu_framer
   import uart_alu_pkg::*;
#(
   parameter int unsigned DBIT    = DBIT_DEF,
   parameter int unsigned NBITS   = NBITS_DEF,
   parameter int unsigned COD_OP  = COD_OP_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DBIT-1:0]   i_data,
   input  logic              rx_done,
   input  logic              tx_done_tick,
   input  logic [NBITS-1:0]  i_alu_result,
   output logic [NBITS-1:0]  o_op_a,
   output logic [NBITS-1:0]  o_op_b,
   output logic [COD_OP-1:0] o_opcode,
   output logic [DBIT-1:0]   o_tx_data,
   output logic              tx_start,
   output logic              o_busy,
   output logic              o_frame_err
);

   localparam int unsigned NB    = NBITS / DBIT;
   localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NBITS-1:0]  op_a_q, op_a_d;
   logic [NBITS-1:0]  op_b_q, op_b_d;
   logic [COD_OP-1:0] opcode_q, opcode_d;
   logic [NBITS-1:0]  result_q, result_d;
   logic [DBIT-1:0]   tx_data_q, tx_data_d;
   logic              tx_start_q, tx_start_d;
   logic              busy_q, busy_d;
   logic              frame_err_q, frame_err_d;
   logic              tx_done_q;
   logic              abort_c;
   logic              timer_clear_c;
   logic              timer_en_c;
   logic              expired_c;

   function automatic logic [DBIT-1:0] byte_of(input logic [NBITS-1:0] word,
                                                input logic [CNT_W-1:0] idx);
      logic [DBIT-1:0] b;
      b = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         if (idx == CNT_W'(i)) b = word[i*DBIT +: DBIT];
      end
      return b;
   endfunction

   assign timer_clear_c = rx_done || ((state_q == ST_RX_A) && (cnt_q == '0));
   assign timer_en_c    = (state_q == ST_RX_A) || (state_q == ST_RX_B) || (state_q == ST_RX_OP);

   rx_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear_c),
      .enable  (timer_en_c),
      .expired (expired_c)
   );

   // Next-state, datapath updates and registered-output decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      opcode_d  = opcode_q;
      result_d  = result_q;
      tx_data_d = tx_data_q;
      abort_c   = 1'b0;

      case (state_q)
         ST_RX_A: begin
            if (rx_done) begin
               for (int unsigned i = 0; i < NB; i++) begin
                  if (cnt_q == CNT_W'(i)) op_a_d[i*DBIT +: DBIT] = i_data;
               end
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_RX_B;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (expired_c) begin
               abort_c = 1'b1;
            end
         end
         ST_RX_B: begin
            if (rx_done) begin
               for (int unsigned i = 0; i < NB; i++) begin
                  if (cnt_q == CNT_W'(i)) op_b_d[i*DBIT +: DBIT] = i_data;
               end
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_RX_OP;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (expired_c) begin
               abort_c = 1'b1;
            end
         end
         ST_RX_OP: begin
            if (rx_done) begin
               opcode_d = i_data[COD_OP-1:0];
               state_d  = ST_EXEC;
            end else if (expired_c) begin
               abort_c = 1'b1;
            end
         end
         ST_EXEC: begin
            result_d  = i_alu_result;
            cnt_d     = '0;
            tx_data_d = i_alu_result[DBIT-1:0];
            state_d   = ST_TX_SEND;
         end
         ST_TX_SEND: begin
            state_d = ST_TX_WAIT;
         end
         ST_TX_WAIT: begin
            if (tx_done_q) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_RX_A;
               end else begin
                  cnt_d     = cnt_q + CNT_W'(1);
                  tx_data_d = byte_of(result_q, cnt_q + CNT_W'(1));
                  state_d   = ST_TX_SEND;
               end
            end
         end
         default: begin
            state_d = ST_RX_A;
            cnt_d   = '0;
         end
      endcase

      if (abort_c) begin
         state_d = ST_RX_A;
         cnt_d   = '0;
      end

      tx_start_d  = (state_d == ST_TX_SEND);
      busy_d      = (state_d == ST_EXEC) || (state_d == ST_TX_SEND) || (state_d == ST_TX_WAIT);
      frame_err_d = abort_c;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RX_A;
         cnt_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         opcode_q    <= '0;
         result_q    <= '0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         opcode_q    <= opcode_d;
         result_q    <= result_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
         // TX completion is staged one cycle, so tx_start trails tx_done_tick by two cycles.
         tx_done_q   <= tx_done_tick && (state_q == ST_TX_WAIT);
      end
   end

   assign o_op_a      = op_a_q;
   assign o_op_b      = op_b_q;
   assign o_opcode    = opcode_q;
   assign o_tx_data   = tx_data_q;
   assign tx_start    = tx_start_q;
   assign o_busy      = busy_q;
   assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_alu_framer.sv
// Self-checking bench for uart_alu_framer: vector table, directed corner cases,
// and randomized frames against a transaction-level reference.
module tb_uart_alu_framer;

   localparam int unsigned TO = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  i_data;
   logic        rx_done;
   logic        tx_done_tick;
   logic [15:0] alu_res;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [5:0]  opcode;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        busy;
   logic        frame_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int tx_cnt = 0;
   int ferr_cnt = 0;
   int last_rx_cyc = 0;
   logic [15:0] model_b = 16'h0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [7:0]  op;
      logic [15:0] res;
   } vec_t;

   vec_t vecs [8];

   uart_alu_framer #(
      .DBIT(8), .NBITS(16), .COD_OP(6), .TIMEOUT(TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_data       (i_data),
      .rx_done      (rx_done),
      .tx_done_tick (tx_done_tick),
      .i_alu_result (alu_res),
      .o_op_a       (op_a),
      .o_op_b       (op_b),
      .o_opcode     (opcode),
      .o_tx_data    (tx_data),
      .tx_start     (tx_start),
      .o_busy       (busy),
      .o_frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_start) tx_cnt <= tx_cnt + 1;
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
   end

   function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         default: return 16'h0000;
      endcase
   endfunction

   assign alu_res = alu_model(op_a, op_b, opcode);

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      last_rx_cyc = cyc;
      i_data  = b;
      rx_done = 1'b1;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
      i_data  = 8'h00;
   endtask

   task automatic pulse_tx_done(output int m);
      m = cyc;
      tx_done_tick = 1'b1;
      @(posedge clk);
      #1;
      tx_done_tick = 1'b0;
   endtask

   task automatic wait_tx(input int budget, output logic [7:0] b, output int c, output bit ok);
      ok = 1'b0;
      b  = 8'h00;
      c  = 0;
      for (int i = 0; i < budget; i++) begin
         if (tx_start) begin
            b  = tx_data;
            c  = cyc;
            ok = 1'b1;
            break;
         end
         idle(1);
      end
   endtask

   // Receive both result bytes, checking latency, data, busy and the drop of a stray RX byte.
   task automatic run_tx(input logic [15:0] exp, input string tag, input int lat_ref, input bit drop);
      logic [7:0] b;
      int c;
      int m;
      bit ok;
      m = 0;
      for (int i = 0; i < 2; i++) begin
         wait_tx(12, b, c, ok);
         check({tag, "_tx_seen"}, 32'(ok), 32'd1);
         if (!ok) return;
         if (i == 0) check({tag, "_lat_first"}, 32'(c), 32'(lat_ref + 2));
         else        check({tag, "_lat_next"}, 32'(c), 32'(m + 2));
         check({tag, "_tx_byte"}, 32'(b), 32'(exp[i*8 +: 8]));
         check({tag, "_busy_tx"}, 32'(busy), 32'd1);
         idle(1 + int'($urandom_range(0, 3)));
         if (drop && i == 0) begin
            send_byte(8'hFF);
            check({tag, "_drop_hold"}, 32'(tx_data), 32'(b));
         end
         pulse_tx_done(m);
      end
      idle(1);
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] opb,
                            input logic [15:0] exp, input string tag, input int gap, input bit drop);
      logic [7:0] bytes [5];
      bytes[0] = a[7:0];
      bytes[1] = a[15:8];
      bytes[2] = b[7:0];
      bytes[3] = b[15:8];
      bytes[4] = opb;
      for (int i = 0; i < 5; i++) begin
         send_byte(bytes[i]);
         if (i < 4 && gap > 0) idle(int'($urandom_range(0, gap)));
      end
      model_b = b;
      check({tag, "_op_a"}, 32'(op_a), 32'(a));
      check({tag, "_op_b"}, 32'(op_b), 32'(b));
      check({tag, "_opcode"}, 32'(opcode), 32'(opb[5:0]));
      run_tx(exp, tag, last_rx_cyc, drop);
   endtask

   // Reset asserted between edges: outputs must clear immediately.
   task automatic reset_check(input string tag);
      reset = 1'b1;
      #1;
      check({tag, "_op_a"}, 32'(op_a), 32'd0);
      check({tag, "_op_b"}, 32'(op_b), 32'd0);
      check({tag, "_opcode"}, 32'(opcode), 32'd0);
      check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(1);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      logic [15:0] ra, rb;
      logic [7:0] opb;
      logic [7:0] ops [5];
      int c, m, t0, fe0, fc, tc;
      bit ok;

      vecs[0] = '{a: 16'h1234, b: 16'h0001, op: 8'h20, res: 16'h1235};
      vecs[1] = '{a: 16'h0005, b: 16'h0007, op: 8'h22, res: 16'hFFFE};
      vecs[2] = '{a: 16'hF0F0, b: 16'hFF00, op: 8'h24, res: 16'hF000};
      vecs[3] = '{a: 16'hF0F0, b: 16'h0F0F, op: 8'h25, res: 16'hFFFF};
      vecs[4] = '{a: 16'h1234, b: 16'hFFFF, op: 8'h26, res: 16'hEDCB};
      vecs[5] = '{a: 16'hFFFF, b: 16'h0001, op: 8'h20, res: 16'h0000};
      vecs[6] = '{a: 16'h0100, b: 16'h0200, op: 8'hE0, res: 16'h0300};
      vecs[7] = '{a: 16'h0001, b: 16'h0002, op: 8'h3F, res: 16'h0000};
      ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24; ops[3] = 8'h25; ops[4] = 8'h26;

      reset        = 1'b1;
      i_data       = 8'h00;
      rx_done      = 1'b0;
      tx_done_tick = 1'b0;
      idle(3);
      reset_check("init");

      foreach (vecs[i]) begin
         run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, $sformatf("vec%0d", i), 0, 1'b0);
      end

      // Partial frame then silence: abort exactly TO edges after the last byte.
      fe0 = ferr_cnt;
      send_byte(8'h34);
      send_byte(8'h12);
      send_byte(8'h01);
      t0 = last_rx_cyc;
      ok = 1'b0;
      fc = 0;
      for (int i = 0; i < int'(TO) + 10; i++) begin
         if (frame_err) begin
            ok = 1'b1;
            fc = cyc;
            break;
         end
         idle(1);
      end
      check("to_seen", 32'(ok), 32'd1);
      check("to_cycle", 32'(fc), 32'(t0 + int'(TO) + 1));
      idle(1);
      check("to_width", 32'(frame_err), 32'd0);
      check("to_count", 32'(ferr_cnt), 32'(fe0 + 1));
      check("to_keep_a", 32'(op_a), 32'h1234);
      check("to_keep_b", 32'(op_b), 32'({model_b[15:8], 8'h01}));
      run_frame(16'h0002, 16'h0003, 8'h20, 16'h0005, "to_next", 0, 1'b0);

      // Byte arriving on the would-expire cycle is accepted.
      fe0 = ferr_cnt;
      send_byte(8'h34);
      idle(int'(TO) - 1);
      send_byte(8'h12);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h20);
      model_b = 16'h0001;
      check("bnd_op_a", 32'(op_a), 32'h1234);
      run_tx(16'h1235, "bnd", last_rx_cyc, 1'b0);
      check("bnd_no_err", 32'(ferr_cnt), 32'(fe0));

      run_frame(16'h1111, 16'h2222, 8'h20, 16'h3333, "drop", 0, 1'b1);
      run_frame(16'h0A0B, 16'h0102, 8'h22, 16'h0909, "after_drop", 0, 1'b0);

      send_byte(8'h34);
      send_byte(8'h12);
      send_byte(8'h01);
      reset_check("rst_frame");
      run_frame(16'h1234, 16'h0001, 8'h20, 16'h1235, "post_rst_frame", 0, 1'b0);

      send_byte(8'h34);
      send_byte(8'h12);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h20);
      wait_tx(12, b, c, ok);
      check("rst_tx_seen", 32'(ok), 32'd1);
      idle(1);
      reset_check("rst_tx");
      tc = tx_cnt;
      pulse_tx_done(m);
      idle(3);
      check("rst_tx_stale", 32'(tx_cnt), 32'(tc));
      check("rst_tx_busy", 32'(busy), 32'd0);
      run_frame(16'h1234, 16'h0001, 8'h20, 16'h1235, "post_rst_tx", 0, 1'b0);

      for (int f = 0; f < 30; f++) begin
         if ($urandom_range(0, 5) == 0) begin
            fe0 = ferr_cnt;
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
               send_byte(8'($urandom));
               idle(int'($urandom_range(0, 3)));
            end
            idle(int'(TO) + 2);
            check("rnd_abort", 32'(ferr_cnt), 32'(fe0 + 1));
         end
         ra = 16'($urandom);
         rb = 16'($urandom);
         c  = int'($urandom_range(0, 5));
         opb = (c == 5) ? 8'($urandom) : ops[c];
         run_frame(ra, rb, opb, alu_model(ra, rb, opb[5:0]), $sformatf("rnd%0d", f), 5,
                   ($urandom_range(0, 3) == 0));
      end

      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_alu_framer.md
# uart_alu_framer

Parametrised successor to the single-byte UART-to-ALU command interface. It sits between the UART receiver/transmitter and the ALU. It assembles multi-byte operands A and B plus an opcode from the RX byte stream, then presents them to the ALU. It returns the multi-byte result through the TX handshake, one byte at a time, and aborts any partial frame after an inter-byte timeout.

## Interface
- `DBIT`, 8: UART byte width.
- `NBITS`, 16: operand/result width; must be an integer multiple of `DBIT`. `NB = NBITS/DBIT` bytes per operand.
- `COD_OP`, 6: opcode width; `COD_OP <= DBIT`.
- `TIMEOUT`, 50000: max idle cycles between RX bytes inside a frame; 0 disables the timeout.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `i_data` in DBIT: received byte, valid when `rx_done`=1.
- `rx_done` in 1: one-cycle RX byte strobe.
- `tx_done_tick` in 1: one-cycle strobe, TX finished the current byte.
- `i_alu_result` in NBITS: combinational ALU result.
- `o_op_a`, `o_op_b` out NBITS: registered operands to the ALU.
- `o_opcode` out COD_OP: registered opcode to the ALU.
- `o_tx_data` out DBIT: byte to transmit; stable from `tx_start` until `tx_done_tick`.
- `tx_start` out 1: one-cycle pulse per TX byte.
- `o_busy` out 1: high in EXEC, TX_SEND, TX_WAIT.
- `o_frame_err` out 1: one-cycle pulse when a frame is aborted by timeout.

## Operation
- Frame format: NB bytes of A, then NB bytes of B, then 1 opcode byte. A and B are little-endian (first byte is bits [DBIT-1:0]). The opcode is taken from `i_data[COD_OP-1:0]`.
- States: RX_A, RX_B, RX_OP, EXEC, TX_SEND, TX_WAIT. There is one shared byte counter `cnt`, range 0..NB-1.
- RX_A / RX_B: on `rx_done`, write `i_data` into byte `cnt` of A / B.
  - If `cnt==NB-1`: clear `cnt` and advance to the next state.
  - Otherwise: increment `cnt`.
- RX_OP: on `rx_done`, latch the opcode, go to EXEC.
- EXEC: lasts exactly 1 cycle. Register `i_alu_result` into an internal result register, set `cnt=0`, go to TX_SEND.
- TX_SEND: lasts 1 cycle. `tx_start`=1 and `o_tx_data` = result byte `cnt`. Go to TX_WAIT.
- TX_WAIT: on `tx_done_tick`:
  - If `cnt==NB-1`: set `cnt=0`, go to RX_A.
  - Otherwise: increment `cnt`, go to TX_SEND.
- `rx_done` in EXEC, TX_SEND or TX_WAIT: the byte is dropped, with no state change.
- `tx_done_tick` outside TX_WAIT: ignored.
- Operand and opcode registers hold their last values until overwritten. They are not cleared by an abort.
- Timeout:
  - The idle timer clears on every `rx_done`, and while in RX_A with `cnt==0`.
  - Otherwise it increments each cycle in RX_A, RX_B and RX_OP.
  - When it reaches `TIMEOUT`:
    - state goes to RX_A, `cnt=0`, timer clears;
    - `o_frame_err` pulses for one cycle.
- Simultaneous `rx_done` and timer expiry: `rx_done` wins. The byte is accepted and the timer clears.
- Reset, asynchronous, at any point including mid-frame or mid-TX:
  - state goes to RX_A; `cnt`, timer, A, B, opcode and result are all 0;
  - `tx_start`=0, `o_busy`=0, `o_frame_err`=0, `o_tx_data`=0;
  - a TX byte already in flight is not tracked after reset.

## Timing
- `o_op_a`, `o_op_b` and `o_opcode` update on the clock edge that samples `rx_done`.
- If the final opcode `rx_done` is sampled in cycle N:
  - EXEC is cycle N+1;
  - first `tx_start` is in cycle N+2.
- Consecutive TX bytes: `tx_start` follows `tx_done_tick` by 2 cycles (TX_WAIT → TX_SEND → pulse).
- The ALU must settle within the EXEC cycle. It sees stable operands for at least 1 full cycle before capture.
- Timeout abort occurs exactly `TIMEOUT` cycles after the last accepted in-frame `rx_done`, with no further `rx_done`.
- `tx_start` and `o_frame_err` are never high for more than 1 consecutive cycle.

## Structure
- Package `uart_alu_pkg`:
  - the state encoding (6 states, 3 bits);
  - the default values of `DBIT`, `NBITS`, `COD_OP` and `TIMEOUT`.
- Sub-module `rx_idle_timer`: inputs `clear` and `enable`, output `expired`. Its width is `$clog2(TIMEOUT+1)`, and it ties `expired` to 0 when `TIMEOUT==0`.
- The ALU is not instantiated inside this block. It is connected at the top level through `o_op_a`, `o_op_b`, `o_opcode` and `i_alu_result`.

## Test plan
Bench setup: `NBITS`=16, `DBIT`=8, reference ALU with ADD=0x20.
- Nominal ADD: RX 0x34,0x12,0x01,0x00,0x20 → `o_op_a`=0x1234, `o_op_b`=0x0001. Then `tx_start` with 0x35, and after `tx_done_tick`, `tx_start` with 0x12. `o_busy` stays high until the second `tx_done_tick`.
- Latency: the opcode `rx_done` in cycle N → `tx_start` in N+2. A `tx_done_tick` in cycle M → the second `tx_start` in M+2.
- Timeout (`TIMEOUT`=20): RX 0x34,0x12,0x01, then idle 20 cycles → `o_frame_err` pulse. A new full frame 0x02,0x00,0x03,0x00,0x20 then yields TX 0x05, 0x00.
- Boundary: `rx_done` in the same cycle the timer would expire → byte accepted, no `o_frame_err`.
- Drop during TX: `rx_done` 0xFF while in TX_WAIT → ignored. The next frame parses correctly from byte 0.
- Reset mid-frame after 3 RX bytes, and again mid-TX → all outputs 0, state RX_A. A subsequent nominal frame passes.
